// File: rtl/tjmono_readout_emu.sv
// TJ-Monopix token/freeze/read emulator: buffers hit words, serializes one per READ edge.
// Latency: TOKEN/HIT_FULL one cycle after write; OUT bit26 the cycle after an accepted READ. Full buffer drops hits (LOST_CNT).
module tjmono_readout_emu #(
    parameter int DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        HIT_WR,
    input  logic [26:0] HIT_DATA,
    output logic        HIT_FULL,
    input  logic        FREEZE,
    input  logic        READ,
    output logic        TOKEN,
    output logic        OUT,
    output logic        BUSY,
    output logic [7:0]  LOST_CNT,
    output logic [7:0]  READ_ERR_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [26:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] fc;
    logic [CW-1:0] fc_nxt;
    logic          freeze_q;
    logic          read_q;
    logic [26:0]   shift;
    logic [4:0]    bit_cnt;
    logic          full;
    logic          push;
    logic          pop;
    logic          read_rise;
    logic          accept;

    always_comb begin
        full      = (count == CW'(DEPTH));
        push      = HIT_WR && !full;
        read_rise = READ && !read_q;
        accept    = read_rise && FREEZE && (fc != '0) && !BUSY;
        pop       = accept;
        count_nxt = count + CW'(push) - CW'(pop);
        // Snapshot uses occupancy before this edge's push/pop; later pushes never raise it.
        fc_nxt    = fc;
        if (!FREEZE) begin
            fc_nxt = '0;
        end else if (!freeze_q) begin
            fc_nxt = count;
        end else if (pop) begin
            fc_nxt = fc - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= HIT_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            fc           <= '0;
            freeze_q     <= 1'b0;
            read_q       <= 1'b0;
            shift        <= '0;
            bit_cnt      <= '0;
            BUSY         <= 1'b0;
            TOKEN        <= 1'b0;
            HIT_FULL     <= 1'b0;
            LOST_CNT     <= '0;
            READ_ERR_CNT <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_nxt;
            fc       <= fc_nxt;
            freeze_q <= FREEZE;
            read_q   <= READ;
            TOKEN    <= FREEZE ? (fc_nxt != '0) : (count_nxt != '0);
            HIT_FULL <= (count_nxt == CW'(DEPTH));

            // Shifting zeros in leaves the register clear once the word is out, so OUT idles low.
            if (accept) begin
                shift   <= mem[rd_ptr];
                bit_cnt <= 5'd26;
                BUSY    <= 1'b1;
            end else if (BUSY) begin
                shift   <= {shift[25:0], 1'b0};
                bit_cnt <= bit_cnt - 5'd1;
                if (bit_cnt == 5'd0) begin
                    BUSY <= 1'b0;
                end
            end

            if (HIT_WR && full && (LOST_CNT != 8'hFF)) begin
                LOST_CNT <= LOST_CNT + 8'd1;
            end
            if (read_rise && !accept && (READ_ERR_CNT != 8'hFF)) begin
                READ_ERR_CNT <= READ_ERR_CNT + 8'd1;
            end
        end
    end

    assign OUT = shift[26];

endmodule

// File: tb/tb_tjmono_readout_emu.sv
// Bench for tjmono_readout_emu: queue-based reference model checked every cycle, plus directed literal checks.
module tb_tjmono_readout_emu;
    localparam int DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        HIT_WR = 1'b0;
    logic [26:0] HIT_DATA = '0;
    logic        FREEZE = 1'b0;
    logic        READ = 1'b0;
    logic        HIT_FULL, TOKEN, OUT, BUSY;
    logic [7:0]  LOST_CNT, READ_ERR_CNT;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    tjmono_readout_emu #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .HIT_WR(HIT_WR), .HIT_DATA(HIT_DATA),
        .HIT_FULL(HIT_FULL), .FREEZE(FREEZE), .READ(READ), .TOKEN(TOKEN),
        .OUT(OUT), .BUSY(BUSY), .LOST_CNT(LOST_CNT), .READ_ERR_CNT(READ_ERR_CNT)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: hit queue, frozen count, and a word transmitted starting at a known edge.
    logic [26:0] q[$];
    logic [26:0] tx_word = '0;
    int  fc = 0, lost = 0, rerr = 0, ecount = 0, tx_start = -100;
    bit  frz_prev = 0, rd_prev = 0, chk_en = 0;
    bit  m_tok = 0, m_out = 0, m_busy = 0, m_full = 0;

    always @(posedge CLK) begin
        int  sz;
        bit  rise, acc, busy_b;
        ecount++;
        if (!RST_N) begin
            q.delete();
            fc = 0; lost = 0; rerr = 0;
            frz_prev = 0; rd_prev = 0;
            tx_start = -100;
            chk_en = 1;
        end else begin
            sz     = q.size();
            busy_b = (ecount - 1 - tx_start) >= 0 && (ecount - 1 - tx_start) <= 26;
            rise   = READ && !rd_prev;
            acc    = rise && FREEZE && (fc > 0) && !busy_b;
            if (acc) begin
                tx_word  = q.pop_front();
                tx_start = ecount;
            end
            if (HIT_WR) begin
                if (sz < DEPTH) q.push_back(HIT_DATA);
                else if (lost < 255) lost++;
            end
            if (rise && !acc && rerr < 255) rerr++;
            if (!FREEZE) fc = 0;
            else if (!frz_prev) fc = sz;
            else if (acc) fc--;
            rd_prev  = READ;
            frz_prev = FREEZE;
        end
        m_busy = (ecount - tx_start) >= 0 && (ecount - tx_start) <= 26;
        m_out  = m_busy ? tx_word[26 - (ecount - tx_start)] : 1'b0;
        m_tok  = frz_prev ? (fc > 0) : (q.size() > 0);
        m_full = (q.size() == DEPTH);
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("TOKEN", TOKEN, m_tok);
            chk("OUT", OUT, m_out);
            chk("BUSY", BUSY, m_busy);
            chk("HIT_FULL", HIT_FULL, m_full);
            chk("LOST_CNT", LOST_CNT, lost);
            chk("READ_ERR_CNT", READ_ERR_CNT, rerr);
        end
    end

    logic tok_k1;
    int   busy_cycles;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST_N = 0; HIT_WR = 0; READ = 0; FREEZE = 0;
        tick; tick;
        RST_N = 1;
    endtask

    task automatic write_hit(input logic [26:0] d);
        HIT_WR = 1; HIT_DATA = d;
        tick;
        HIT_WR = 0;
    endtask

    task automatic pulse_read;
        READ = 1; tick;
        READ = 0; tick;
    endtask

    // READ edge then capture 27 bits; optional extra READ rise, FREEZE drop, reset, write-at-accept.
    task automatic serial_read(input int rise_at, input int frz_drop_at, input int rst_at,
                               input bit wr_acc, input logic [26:0] wd, output logic [26:0] w);
        w = '0;
        busy_cycles = 0;
        READ = 1;
        if (wr_acc) begin HIT_WR = 1; HIT_DATA = wd; end
        tick;
        READ = 0; HIT_WR = 0;
        tok_k1 = TOKEN;
        for (int i = 0; i < 27; i++) begin
            w[26 - i] = OUT;
            if (BUSY) busy_cycles++;
            if (i == rise_at) READ = 1;
            if (i == rise_at + 1) READ = 0;
            if (i == frz_drop_at) FREEZE = 0;
            if (i == rst_at) begin
                RST_N = 0;
                tick;
                chk("rstmid_OUT", OUT, 0);
                chk("rstmid_BUSY", BUSY, 0);
                chk("rstmid_TOKEN", TOKEN, 0);
                chk("rstmid_LOST", LOST_CNT, 0);
                chk("rstmid_RERR", READ_ERR_CNT, 0);
                RST_N = 1;
                return;
            end
            tick;
        end
    endtask

    initial begin
        logic [26:0] w;
        logic [26:0] hv [4];
        hv[0] = 27'h1234567; hv[1] = 27'h7654321; hv[2] = 27'h0ABCDEF; hv[3] = 27'h7FFFFFF;

        do_reset;
        chk("reset_TOKEN", TOKEN, 0);
        chk("reset_BUSY", BUSY, 0);
        chk("reset_HIT_FULL", HIT_FULL, 0);

        // Basic word
        write_hit(27'h5A5A5A5);
        FREEZE = 1; tick; tick;
        serial_read(-1, -1, -1, 0, '0, w);
        chk("basic_word", w, 27'h5A5A5A5);
        chk("basic_tok_k1", tok_k1, 0);
        chk("basic_busy_len", busy_cycles, 27);
        chk("basic_busy_end", BUSY, 0);
        FREEZE = 0; tick;

        // Freeze snapshot with simultaneous 4th write
        do_reset;
        for (int i = 0; i < 3; i++) write_hit(hv[i]);
        FREEZE = 1; HIT_WR = 1; HIT_DATA = hv[3];
        tick;
        HIT_WR = 0; tick;
        for (int i = 0; i < 3; i++) begin
            serial_read(-1, -1, -1, 0, '0, w);
            chk("snap_word", w, hv[i]);
            tick; tick;
        end
        pulse_read;
        chk("snap_rerr", READ_ERR_CNT, 1);
        chk("snap_tok_frozen", TOKEN, 0);
        FREEZE = 0; tick;
        chk("snap_tok_release", TOKEN, 1);

        // Overflow
        do_reset;
        for (int i = 0; i < 18; i++) begin
            write_hit(27'h100 + 27'(i));
            if (i == 14) chk("ovf_not_full", HIT_FULL, 0);
            if (i == 15) chk("ovf_full", HIT_FULL, 1);
        end
        chk("ovf_lost", LOST_CNT, 2);
        FREEZE = 1; tick; tick;
        for (int i = 0; i < 16; i++) begin
            serial_read(-1, -1, -1, 0, '0, w);
            chk("ovf_word", w, 27'h100 + 27'(i));
        end
        chk("ovf_tok_empty", TOKEN, 0);
        FREEZE = 0; tick;

        // READ rising edge while BUSY
        do_reset;
        write_hit(27'h3C3C3C3); write_hit(27'h0F0F0F0);
        FREEZE = 1; tick; tick;
        serial_read(9, -1, -1, 0, '0, w);
        chk("busy_word1", w, 27'h3C3C3C3);
        chk("busy_rerr", READ_ERR_CNT, 1);
        serial_read(-1, -1, -1, 0, '0, w);
        chk("busy_word2", w, 27'h0F0F0F0);
        FREEZE = 0; tick;

        // Push+pop at the accepting edge, FREEZE dropped mid-word
        do_reset;
        write_hit(27'h1111111); write_hit(27'h2222222);
        FREEZE = 1; tick; tick;
        serial_read(-1, 5, -1, 1, 27'h3333333, w);
        chk("pp_word", w, 27'h1111111);
        chk("pp_tok", TOKEN, 1);
        FREEZE = 1; tick; tick;
        serial_read(-1, -1, -1, 0, '0, w);
        chk("pp_word2", w, 27'h2222222);
        serial_read(-1, -1, -1, 0, '0, w);
        chk("pp_word3", w, 27'h3333333);
        chk("pp_tok_empty", TOKEN, 0);
        FREEZE = 0; tick;

        // Reset mid-word
        do_reset;
        write_hit(27'h6DB6DB6);
        FREEZE = 1; tick; tick;
        serial_read(-1, -1, 9, 0, '0, w);
        tick; tick;
        pulse_read;
        chk("rstmid_rerr", READ_ERR_CNT, 1);
        chk("rstmid_idle", BUSY, 0);
        tick; tick;
        FREEZE = 0; tick;

        // Randomized traffic
        do_reset;
        for (int c = 0; c < 5000; c++) begin
            HIT_WR   = ($urandom_range(0, 99) < 35);
            HIT_DATA = 27'($urandom);
            READ     = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 99) < 3) FREEZE = ~FREEZE;
            RST_N    = ($urandom_range(0, 999) != 0);
            tick;
        end
        RST_N = 1; HIT_WR = 0; READ = 0;
        tick; tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
